// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: drains a wide FIFO through a 2-slot buffer
// and emits each word as LSB-first narrow beats on valid/ready.
module fifo_rd_serializer #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [IN_W-1:0]  fifo_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int N     = IN_W / OUT_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IN_W-1:0]  r_cur;
  logic [IN_W-1:0]  r_nxt;
  logic             r_cur_v;
  logic             r_nxt_v;
  logic             r_inflight;
  logic [IDX_W-1:0] r_beat;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_occ;
  logic [1:0]       w_own;
  logic             w_pop;
  logic             w_fire;
  logic             w_last;
  logic             w_rel;
  logic             w_cur_free;
  logic             w_cap_cur;
  logic             w_cap_nxt;
  logic [N-1:0][OUT_W-1:0] w_beats;

  assign w_occ = {1'b0, r_cur_v} + {1'b0, r_nxt_v};
  assign w_own = w_occ + {1'b0, r_inflight};
  assign w_pop = reset & ~fifo_empty & (w_own < 2'd2);

  assign w_fire = r_cur_v & out_ready;
  assign w_last = (r_beat == LAST);
  assign w_rel  = w_fire & w_last;

  // head slot is free for the returning word if empty or
  // vacating this cycle with nothing queued behind it
  assign w_cur_free = ~r_cur_v | (w_rel & ~r_nxt_v);
  assign w_cap_cur  = r_inflight & w_cur_free;
  assign w_cap_nxt  = r_inflight & ~w_cur_free;

  assign w_beats    = r_cur;
  assign fifo_rd_en = w_pop;
  assign out_valid  = r_cur_v;
  assign out_data   = w_beats[r_beat];
  assign out_last   = r_cur_v & w_last;
  assign word_cnt   = r_cnt;

  // slot shift on last beat, then capture of the returning read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur      <= '0;
      r_nxt      <= '0;
      r_cur_v    <= 1'b0;
      r_nxt_v    <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_pop;
      if (w_rel) begin
        r_cur   <= r_nxt;
        r_cur_v <= r_nxt_v;
        r_nxt_v <= 1'b0;
      end
      if (w_cap_cur) begin
        r_cur   <= fifo_rd_data;
        r_cur_v <= 1'b1;
      end
      if (w_cap_nxt) begin
        r_nxt   <= fifo_rd_data;
        r_nxt_v <= 1'b1;
      end
    end
  end

  // beat index within the head word and emitted-word count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat <= '0;
      r_cnt  <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_beat <= '0;
        r_cnt  <= r_cnt + 1'b1;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// tb_fifo_rd_serializer: directed checks of the read serializer
// against a behavioural 1-cycle-latency FIFO model.
module tb_fifo_rd_serializer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [127:0] fifo_rd_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         out_last;
  logic [31:0]  word_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [127:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  int pops = 0;
  int own = 0;
  int max_own = 0;
  int bad_pop = 0;
  int cyc = 0;

  logic [31:0] bq[$];
  logic        lq[$];
  int          cq[$];

  fifo_rd_serializer #(
    .IN_W(128), .OUT_W(32), .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rp == wp);

  // FIFO model: data valid the cycle after a pop
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rp % 64];
      rp   <= rp + 1;
      pops <= pops + 1;
    end
    if (!reset)
      own <= 0;
    else
      own <= own + (fifo_rd_en ? 1 : 0)
                 - ((out_valid && out_ready && out_last) ? 1 : 0);
  end

  // mid-cycle monitor of beats and invariants
  always @(negedge clk) begin
    if (own > max_own) max_own = own;
    if (reset) begin
      if (fifo_rd_en && fifo_empty) bad_pop = bad_pop + 1;
      if (out_valid && out_ready) begin
        bq.push_back(out_data);
        lq.push_back(out_last);
        cq.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] w);
    mem[wp % 64] = w;
    wp = wp + 1;
  endtask

  function automatic logic [31:0] bt(input int k, input int j);
    return 32'((k << 8) | j);
  endfunction

  function automatic logic [127:0] mkw(input int k);
    return {bt(k, 3), bt(k, 2), bt(k, 1), bt(k, 0)};
  endfunction

  task automatic clr();
    bq.delete();
    lq.delete();
    cq.delete();
  endtask

  task automatic wait_beats(input string tag, input int n,
                            input int budget);
    int i;
    i = 0;
    while (bq.size() < n && i < budget) begin
      step();
      i++;
    end
    check(tag, bq.size(), n);
  endtask

  task automatic chk_words(input string tag, input int k0,
                           input int nw);
    int bad;
    int badl;
    bad  = 0;
    badl = 0;
    for (int i = 0; i < nw * 4; i++) begin
      if (i < bq.size()) begin
        if (bq[i] !== bt(k0 + i / 4, i % 4)) bad++;
        if (lq[i] !== ((i % 4) == 3)) badl++;
      end
    end
    check({tag, "_data"}, bad, 0);
    check({tag, "_last"}, badl, 0);
  endtask

  initial begin
    logic [31:0] exp1 [4];
    int p0;
    int rel;
    int gaps;
    int bad;

    exp1[0] = 32'h11111111;
    exp1[1] = 32'h22222222;
    exp1[2] = 32'h33333333;
    exp1[3] = 32'h44444444;

    // reset held with a non-empty FIFO
    push(128'h44444444_33333333_22222222_11111111);
    repeat (3) step();
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);

    // single word
    out_ready = 1'b1;
    p0 = pops;
    reset = 1'b1;
    rel = cyc;
    clr();
    wait_beats("one_wait", 4, 20);
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i < bq.size() && bq[i] !== exp1[i]) bad++;
    check("one_data", bad, 0);
    check("one_last0", lq[0], 0);
    check("one_last3", lq[3], 1);
    check("one_lat", cq[0] - rel, 2);
    repeat (2) step();
    check("one_cnt", word_cnt, 1);
    check("one_pops", pops - p0, 1);
    check("one_idle", out_valid, 0);

    // streaming 8 words
    clr();
    p0 = pops;
    max_own = 0;
    for (int k = 1; k <= 8; k++) push(mkw(k));
    wait_beats("str_wait", 32, 100);
    chk_words("str", 1, 8);
    gaps = 0;
    for (int i = 1; i < cq.size(); i++)
      if (cq[i] != cq[i-1] + 1) gaps++;
    check("str_gaps", gaps, 0);
    repeat (2) step();
    check("str_cnt", word_cnt, 9);
    check("str_pops", pops - p0, 8);
    check("str_badpop", bad_pop, 0);
    check("str_own", max_own <= 2, 1);

    // backpressure at beat 2
    clr();
    for (int k = 20; k <= 22; k++) push(mkw(k));
    begin
      int i;
      i = 0;
      while (!out_valid && i < 20) begin
        step();
        i++;
      end
    end
    check("bp_valid", out_valid, 1);
    repeat (2) step();
    out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_hold_v", out_valid, 1);
      check("bp_hold_d", out_data, bt(20, 2));
      step();
    end
    check("bp_pops", (pops - p0) <= 1, 1);
    check("bp_own", max_own <= 2, 1);
    out_ready = 1'b1;
    wait_beats("bp_wait", 12, 60);
    chk_words("bp", 20, 3);
    repeat (2) step();
    check("bp_cnt", word_cnt, 12);

    // empty boundary then refill
    clr();
    push(mkw(30));
    wait_beats("emp_wait1", 4, 20);
    repeat (2) step();
    check("emp_drop", out_valid, 0);
    repeat (3) step();
    rel = cyc;
    push(mkw(31));
    wait_beats("emp_wait2", 8, 20);
    check("emp_lat", cq[4] - rel, 2);
    chk_words("emp", 30, 2);
    repeat (2) step();
    check("emp_cnt", word_cnt, 14);
    check("emp_badpop", bad_pop, 0);

    // reset mid-word (beat 1 of third word)
    clr();
    for (int k = 40; k <= 43; k++) push(mkw(k));
    wait_beats("mid_wait", 9, 60);
    check("mid_pre_d", out_data, bt(42, 1));
    reset = 1'b0;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_cnt", word_cnt, 0);
    check("mid_data", out_data, 0);
    check("mid_rd_en", fifo_rd_en, 0);
    repeat (2) step();
    reset = 1'b1;
    clr();
    push(mkw(44));
    wait_beats("mid_wait2", 4, 20);
    chk_words("mid", 44, 1);
    repeat (2) step();
    check("mid_cnt2", word_cnt, 1);
    check("mid_own", max_own <= 2, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
